// File: rtl/down_counter_reg.sv
// Programmable down-counter with a staged input register. It emits a registered
// borrow pulse at terminal count and can optionally auto-reload for periodic timing.
module down_counter_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             tick,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_in,
  input  logic             load_cnt,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] in_reg_q, in_reg_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             borrow_q, borrow_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      in_reg_q <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_reg_q <= in_reg_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    borrow_d = 1'b0;
    in_reg_d = load_in ? data_in : in_reg_q;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!load_cnt && tick) begin
          if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            borrow_d = 1'b1;
            if (auto_reload) count_d = in_reg_q;
            else             state_d = DONE;
          end
        end
      end
      DONE: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    // Loading the counter always uses the pre-edge input register value.
    if (load_cnt) count_d = in_reg_q;
  end

  assign count  = count_q;
  assign zero   = (count_q == '0);
  assign borrow = borrow_q;
  assign busy   = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_reg.sv
// Bench for down_counter_reg: table-driven vectors with a queue of expected
// outputs, plus a hand sequence for the asynchronous mid-count reset.
module tb_down_counter_reg;

  logic       clk;
  logic       clr;
  logic       tick;
  logic [7:0] data_in;
  logic       load_in;
  logic       load_cnt;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [7:0] count;
  logic       zero;
  logic       borrow;
  logic       busy;

  int tests_run;
  int tests_failed;

  down_counter_reg #(.WIDTH(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .tick       (tick),
    .data_in    (data_in),
    .load_in    (load_in),
    .load_cnt   (load_cnt),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .count      (count),
    .zero       (zero),
    .borrow     (borrow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tk;
    logic       li;
    logic [7:0] d;
    logic       lc;
    logic       st;
    logic       sp;
    logic       ar;
    logic [7:0] e_count;
    logic       e_borrow;
    logic       e_busy;
  } vec_t;

  typedef struct {
    logic [7:0] count;
    logic       zero;
    logic       borrow;
    logic       busy;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic add(input logic tk, input logic li, input logic [7:0] d,
                     input logic lc, input logic st, input logic sp, input logic ar,
                     input logic [7:0] ec, input logic eb, input logic ebu);
    vec_t v;
    v.tk = tk; v.li = li; v.d = d; v.lc = lc; v.st = st; v.sp = sp; v.ar = ar;
    v.e_count = ec; v.e_borrow = eb; v.e_busy = ebu;
    vecs.push_back(v);
  endtask

  task automatic expect_out(input logic [7:0] ec, input logic eb, input logic ebu, input int id);
    exp_t e;
    e.count = ec; e.zero = (ec == 8'h00); e.borrow = eb; e.busy = ebu; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = exp_q.pop_front();
      if (count !== e.count) begin
        tests_failed++;
        $display("FAIL count step%0d: got %02h, required %02h", e.id, count, e.count);
      end
      tests_run++;
      if (zero !== e.zero) begin
        tests_failed++;
        $display("FAIL zero step%0d: got %b, required %b", e.id, zero, e.zero);
      end
      tests_run++;
      if (borrow !== e.borrow) begin
        tests_failed++;
        $display("FAIL borrow step%0d: got %b, required %b", e.id, borrow, e.borrow);
      end
      tests_run++;
      if (busy !== e.busy) begin
        tests_failed++;
        $display("FAIL busy step%0d: got %b, required %b", e.id, busy, e.busy);
      end
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    @(negedge clk);
    tick = v.tk; load_in = v.li; data_in = v.d; load_cnt = v.lc;
    start = v.st; stop = v.sp; auto_reload = v.ar;
    expect_out(v.e_count, v.e_borrow, v.e_busy, id);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle_run;
    tests_run = 0;
    tests_failed = 0;
    clr = 1'b1; tick = 1'b0; data_in = 8'h00; load_in = 1'b0; load_cnt = 1'b0;
    start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
    #1;
    expect_out(8'h00, 1'b0, 1'b0, 0);
    check_out();
    @(negedge clk);
    clr = 1'b0;

    //  tk li  d     lc st sp ar  count  brw busy
    // one-shot count from 3
    add(0, 1, 8'h03, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 8'h03, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 8'h03, 0, 1);
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h02, 0, 1);
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h01, 0, 1);
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1);
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    // auto-reload with period 3, restarted from DONE
    add(0, 1, 8'h02, 0, 0, 0, 1, 8'h00, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 1, 8'h02, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 1, 8'h02, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      add(1, 0, 8'h00, 0, 0, 0, 1, (k % 3 == 0) ? 8'h02 : 8'(2 - (k % 3)), (k % 3 == 0), 1);
    end
    for (int k = 0; k < 50; k++) add(0, 0, 8'h00, 0, 0, 0, 1, 8'h02, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1, 1, 8'h02, 0, 0);
    // same-edge load_in and load_cnt
    add(0, 1, 8'h10, 0, 0, 0, 0, 8'h02, 0, 0);
    add(0, 1, 8'h20, 1, 0, 0, 0, 8'h10, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 8'h20, 0, 0);
    // priority in RUN
    add(0, 1, 8'h05, 0, 0, 0, 0, 8'h20, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 8'h05, 0, 0);
    add(0, 1, 8'h09, 0, 0, 0, 0, 8'h05, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 8'h05, 0, 1);
    add(1, 0, 8'h00, 1, 0, 0, 0, 8'h09, 0, 1);
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h08, 0, 1);
    add(1, 0, 8'h00, 0, 1, 1, 0, 8'h08, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h08, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 8'h08, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1);
    add(1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    // in_reg=0 one-shot, then start+stop in DONE
    add(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1);
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0);
    add(0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
    // set up RUN at 0x37 for the async reset
    add(0, 1, 8'h37, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 8'h37, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 8'h37, 0, 1);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    // clr between edges must clear state without a clock
    @(negedge clk);
    tick = 1'b0; load_in = 1'b0; load_cnt = 1'b0; start = 1'b0; stop = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    expect_out(8'h00, 1'b0, 1'b0, 1000);
    check_out();
    @(negedge clk);
    clr = 1'b0;
    idle_run = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    apply(idle_run, 1001);

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard: %0d expected entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/down_counter_reg.md
Name: down_counter_reg

Overview:
- 8-bit programmable down-counter with a staged input register. It is the count-down counterpart of the up-counter/output-register path.
- It is clocked at full `clk` and advanced by a one-cycle `tick` strobe from the clock divider.
- It produces a registered one-cycle `borrow` pulse at terminal count.
- It optionally auto-reloads from the input register, so it works as a programmable timer/period generator for the board top level.

Parameters:
- WIDTH, 8, width of input register, counter and data ports.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  asynchronous, active-high reset.
- tick  input  1  count-enable strobe, one clk cycle wide, from clock divider.
- data_in  input  WIDTH  parallel load data.
- load_in  input  1  capture data_in into input register.
- load_cnt  input  1  transfer input register into counter.
- start  input  1  begin/resume counting.
- stop  input  1  halt counting, return to IDLE.
- auto_reload  input  1  1 = reload from input register at terminal count; 0 = one-shot.
- count  output  WIDTH  current counter value.
- zero  output  1  count == 0 (combinational from counter register).
- borrow  output  1  registered terminal-count pulse, one clk cycle.
- busy  output  1  high in RUN state.

Behaviour:
- Reset (clr=1, asynchronous): in_reg=0, count=0, state=IDLE, borrow=0, busy=0. zero=1 follows from count=0.
- Input register:
  - load_in=1 at an edge -> in_reg <= data_in. Allowed in any state.
  - Otherwise in_reg holds.
- Counter update priority, highest first: clr, load_cnt, RUN-state tick, hold.
  - load_cnt: count <= in_reg, using the in_reg value before any same-edge load_in update (old value).
  - load_cnt in RUN suppresses that cycle's tick: no decrement, no borrow.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - count holds; tick ignored.
  - start=1 and stop=0 -> RUN.
- RUN:
  - stop=1 -> IDLE next edge; count holds its value; no borrow that cycle, even if tick=1.
  - tick=1 and count!=0 -> count <= count-1.
  - tick=1 and count==0 -> borrow <= 1 next cycle. Then:
    - auto_reload=1: count <= in_reg, stay RUN.
    - auto_reload=0: count stays 0, go to DONE.
  - Period in auto-reload mode = in_reg+1 ticks. in_reg=0 gives a borrow on every tick.
  - tick=0 -> hold.
- DONE:
  - count holds; tick ignored; busy=0.
  - start=1 and stop=0 -> RUN.
  - stop=1 -> IDLE.
  - A load_cnt before restart allows a new count.
- Simultaneous start and stop: stop wins, in every state.
- borrow is high for exactly one clk cycle per terminal-count tick. Otherwise 0.
- busy = (state==RUN), decoded from the state register, no extra latency.
- Arithmetic is modulo 2^WIDTH. Decrement never occurs from 0: terminal count handles that case, so there is no wrap to 255.
- Reset asserted mid-count clears everything immediately, without waiting for clk. First edge after clr deasserts leaves the block in IDLE.

Test Plan:
- Reset: clr=1 mid-RUN with count=0x37 -> count=0x00, zero=1, busy=0, borrow=0 immediately, before next clk edge.
- One-shot: load_in data_in=0x03, load_cnt, auto_reload=0, start, 4 ticks:
  - count goes 3,2,1,0.
  - The 4th tick gives borrow=1 for exactly one cycle, state DONE, busy=0.
  - Further ticks leave count at 0 with no borrow.
- Auto-reload: in_reg=0x02, auto_reload=1, 9 ticks -> borrow after ticks 3, 6 and 9; count reloads to 0x02 each time.
- Same-edge loads: in_reg=0x10; assert load_in (data_in=0x20) and load_cnt on the same edge -> count=0x10, in_reg=0x20.
- Priority in RUN with count=0x05:
  - load_cnt with tick on the same edge (in_reg=0x09) -> count=0x09, no decrement.
  - start and stop together -> IDLE.
  - stop with tick at count=0 -> no borrow, IDLE.
- Gated ticks: tick held 0 for 50 cycles in RUN -> count unchanged; tick in IDLE/DONE -> no change.
